// File: rtl/uart_tx_tmr_ctrl.sv
// Fault monitor and resync sequencer for a triplicated UART TX path (monitor only, never drives TX).
// Optional saturating fault counter on err_count when UART_TX_TMR_CTRL_STATS_EN is defined.
`timescale 1ns/1ps
module uart_tx_tmr_ctrl #(
  parameter int unsigned MISMATCH_LIMIT = 16,
  parameter int unsigned IDLE_CYCLES    = 160
`ifdef UART_TX_TMR_CTRL_STATS_EN
  ,
  parameter int unsigned CNT_W          = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_a,
  input  logic       tx_b,
  input  logic       tx_c,
  input  logic       enable,
  input  logic       resync_ack,
  output logic       resync_req,
  output logic [2:0] lane_fault,
  output logic       double_fault,
  output logic       fault_irq,
  output logic [1:0] state
`ifdef UART_TX_TMR_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    ST_MONITOR   = 2'b00,
    ST_WAIT_IDLE = 2'b01,
    ST_RESYNC    = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_run [3];
  logic [15:0] r_idle;
  logic        w_vote;
  logic [2:0]  w_dis;
  logic [2:0]  w_hit;
  logic [2:0]  w_fault_nxt;
  logic        w_clear;
  logic        w_rise;
  logic        w_idle_done;

  assign w_vote  = (tx_a & tx_b) | (tx_b & tx_c) | (tx_a & tx_c);
  assign w_dis   = {tx_c, tx_b, tx_a} ^ {3{w_vote}};
  // Ack only counts in RESYNC; the clear it causes beats any fault rising at the same edge.
  assign w_clear = (r_state == ST_RESYNC) && resync_ack;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < 3; i++) begin
      w_hit[i] = enable && w_dis[i] && (r_run[i] == 8'(MISMATCH_LIMIT - 1));
    end
  end

  assign w_fault_nxt = w_clear ? 3'b000 : (lane_fault | w_hit);
  assign w_rise      = |(w_fault_nxt & ~lane_fault);
  assign w_idle_done = (r_state == ST_WAIT_IDLE) && w_vote && (r_idle == 16'(IDLE_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_MONITOR:   if (|lane_fault) w_state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (w_idle_done) w_state_nxt = ST_RESYNC;
      ST_RESYNC:    if (resync_ack)  w_state_nxt = ST_MONITOR;
      default:      w_state_nxt = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_MONITOR;
      resync_req   <= 1'b0;
      lane_fault   <= 3'b000;
      double_fault <= 1'b0;
      fault_irq    <= 1'b0;
      r_idle       <= '0;
      for (int i = 0; i < 3; i++) r_run[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      resync_req   <= (w_state_nxt == ST_RESYNC);
      lane_fault   <= w_fault_nxt;
      double_fault <= !w_clear && (double_fault ||
                      (w_fault_nxt[0] & w_fault_nxt[1]) ||
                      (w_fault_nxt[1] & w_fault_nxt[2]) ||
                      (w_fault_nxt[0] & w_fault_nxt[2]));
      fault_irq    <= w_rise;
      if (r_state == ST_WAIT_IDLE && w_vote) r_idle <= r_idle + 16'd1;
      else                                   r_idle <= '0;
      for (int i = 0; i < 3; i++) begin
        if (w_clear || !enable || !w_dis[i])          r_run[i] <= '0;
        else if (r_run[i] != 8'(MISMATCH_LIMIT))      r_run[i] <= r_run[i] + 8'd1;
      end
    end
  end

  assign state = r_state;

`ifdef UART_TX_TMR_CTRL_STATS_EN
  logic [CNT_W-1:0] r_err_count;
  always_ff @(posedge clk) begin
    if (rst)                             r_err_count <= '0;
    else if (w_rise && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
  end
  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_uart_tx_tmr_ctrl.sv
// Directed bench for uart_tx_tmr_ctrl with MISMATCH_LIMIT=16, IDLE_CYCLES=160.
`timescale 1ns/1ps
module tb_uart_tx_tmr_ctrl;
  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst, tx_a, tx_b, tx_c, enable, resync_ack;
  logic       resync_req, double_fault, fault_irq;
  logic [2:0] lane_fault;
  logic [1:0] state;
`ifdef UART_TX_TMR_CTRL_STATS_EN
  logic [CNT_W-1:0] err_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int irq_cnt = 0;

  uart_tx_tmr_ctrl #(
    .MISMATCH_LIMIT(16),
    .IDLE_CYCLES(160)
`ifdef UART_TX_TMR_CTRL_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .tx_a(tx_a), .tx_b(tx_b), .tx_c(tx_c),
    .enable(enable), .resync_ack(resync_ack), .resync_req(resync_req),
    .lane_fault(lane_fault), .double_fault(double_fault),
    .fault_irq(fault_irq), .state(state)
`ifdef UART_TX_TMR_CTRL_STATS_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (fault_irq) irq_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic a, input logic b, input logic c);
    tx_a = a; tx_b = b; tx_c = c;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 400 && !resync_req; i++) tick();
    chk(tag, {31'd0, resync_req}, 32'd1);
  endtask

  task automatic fault_b_cycle();
    lanes(1, 0, 1); tick(16);
    lanes(1, 1, 1);
    wait_req("cyc_req");
    resync_ack = 1'b1; tick();
    resync_ack = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; resync_ack = 1'b0; lanes(1, 1, 1);
    tick(2);
    chk("rst_req", {31'd0, resync_req}, 32'd0);
    chk("rst_fault", {29'd0, lane_fault}, 32'd0);
    chk("rst_double", {31'd0, double_fault}, 32'd0);
    chk("rst_irq", {31'd0, fault_irq}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);

    rst = 1'b0; enable = 1'b1; tick(2);
    irq_cnt = 0;

    // 15-cycle mismatch is transient
    lanes(1, 0, 1); tick(15);
    lanes(1, 1, 1); tick(3);
    chk("short_fault", {29'd0, lane_fault}, 32'd0);
    chk("short_irq", irq_cnt, 0);
    chk("short_state", {30'd0, state}, 32'd0);

    // 16-cycle mismatch latches lane b
    lanes(1, 0, 1); tick(16);
    chk("b_fault", {29'd0, lane_fault}, 32'b010);
    chk("b_irq_hi", {31'd0, fault_irq}, 32'd1);
    lanes(1, 1, 1); tick();
    chk("b_irq_lo", {31'd0, fault_irq}, 32'd0);
    chk("b_state", {30'd0, state}, 32'd1);
    chk("b_irq_cnt", irq_cnt, 1);
    tick(159);
    chk("idle_160_req", {31'd0, resync_req}, 32'd0);
    tick();
    chk("idle_161_req", {31'd0, resync_req}, 32'd1);
    chk("idle_161_state", {30'd0, state}, 32'd2);
    tick(5);
    chk("hold_req", {31'd0, resync_req}, 32'd1);
    resync_ack = 1'b1; tick();
    chk("ack_req", {31'd0, resync_req}, 32'd0);
    chk("ack_fault", {29'd0, lane_fault}, 32'd0);
    chk("ack_state", {30'd0, state}, 32'd0);
    tick(2);
    chk("ack_long_state", {30'd0, state}, 32'd0);
    chk("ack_long_req", {31'd0, resync_req}, 32'd0);
    resync_ack = 1'b0; tick();

    // Idle run broken by one v=0 cycle at count 100
    lanes(1, 0, 1); tick(16);
    lanes(1, 1, 1); tick();
    tick(100);
    lanes(0, 0, 0); tick();
    lanes(1, 1, 1); tick(159);
    chk("intr_req_lo", {31'd0, resync_req}, 32'd0);
    chk("intr_state", {30'd0, state}, 32'd1);
    tick();
    chk("intr_req_hi", {31'd0, resync_req}, 32'd1);
    resync_ack = 1'b1; tick();
    resync_ack = 1'b0; tick();
    chk("intr_clr", {29'd0, lane_fault}, 32'd0);

    // Lane a, then lane c during WAIT_IDLE
    irq_cnt = 0;
    lanes(0, 1, 1); tick(16);
    chk("a_fault", {29'd0, lane_fault}, 32'b001);
    lanes(1, 1, 1); tick();
    chk("a_state", {30'd0, state}, 32'd1);
    lanes(1, 1, 0); tick(16);
    chk("ac_fault", {29'd0, lane_fault}, 32'b101);
    chk("ac_double", {31'd0, double_fault}, 32'd1);
    chk("ac_irq", {31'd0, fault_irq}, 32'd1);
    lanes(1, 1, 1);
    wait_req("ac_req");
    chk("ac_irq_cnt", irq_cnt, 2);
    chk("ac_req_state", {30'd0, state}, 32'd2);
    resync_ack = 1'b1; tick();
    resync_ack = 1'b0;
    chk("ac_clr_fault", {29'd0, lane_fault}, 32'd0);
    chk("ac_clr_double", {31'd0, double_fault}, 32'd0);
    tick();

    // Reset while RESYNC is pending
    lanes(1, 0, 1); tick(16);
    lanes(1, 1, 1);
    wait_req("rr_req");
    rst = 1'b1; tick();
    chk("rr_req_lo", {31'd0, resync_req}, 32'd0);
    chk("rr_state", {30'd0, state}, 32'd0);
    chk("rr_fault", {29'd0, lane_fault}, 32'd0);
    rst = 1'b0; tick();

    // enable=0 blocks detection; counting restarts from zero on enable
    irq_cnt = 0;
    enable = 1'b0; lanes(1, 1, 0); tick(40);
    chk("dis_fault", {29'd0, lane_fault}, 32'd0);
    chk("dis_irq", irq_cnt, 0);
    enable = 1'b1; tick(15);
    chk("en15_fault", {29'd0, lane_fault}, 32'd0);
    tick();
    chk("en16_fault", {29'd0, lane_fault}, 32'b100);
    lanes(1, 1, 1);
    rst = 1'b1; tick();
    rst = 1'b0; tick();

`ifdef UART_TX_TMR_CTRL_STATS_EN
    chk("stat_rst", {30'd0, err_count}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      fault_b_cycle();
      chk("stat_cnt", {30'd0, err_count}, (k < 3) ? k : 3);
    end
    chk("stat_state", {30'd0, state}, 32'd0);
`else
    fault_b_cycle();
    chk("cyc_state", {30'd0, state}, 32'd0);
    chk("cyc_fault", {29'd0, lane_fault}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
